// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional alignment checking in dmem_responder is enabled with DMEM_ALIGN_CHK_EN.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte address to word index; depth is a power of two so masking wraps the address.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input int unsigned depth);
        return (addr >> 2) & (64'(depth) - 64'd1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: per-byte-lane synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Byte-lane write port
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i]) begin
                mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core's load/store request interface.
// Define DMEM_ALIGN_CHK_EN to flag misaligned accesses with rsp_err instead of word-aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_latency_chk
        $error("dmem_responder: LATENCY must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("dmem_responder: DEPTH must be a power of two >= 2");
    end

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic              we_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;

    logic              accept_s;
    logic              misalign_s;
    logic              arr_we_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [IDX_W-1:0]  arr_idx_s;
    logic [WORD_W-1:0] arr_rdata_s;

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign_s = (req_addr[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign req_idx_s = IDX_W'(word_index(64'(req_addr), DEPTH));
    assign accept_s  = (state_q == ST_IDLE) && req_ready_q && req_valid;
    // Stores commit on the accept edge; misaligned ones never touch memory.
    assign arr_we_s  = accept_s && req_we && !misalign_s;
    // Only one access is ever outstanding, so the captured index addresses the array outside IDLE.
    assign arr_idx_s = (state_q == ST_IDLE) ? req_idx_s : idx_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .be    (req_be),
        .idx   (arr_idx_s),
        .wdata (req_wdata),
        .rdata (arr_rdata_s)
    );

    // Request/response FSM with latency counter and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        we_q        <= req_we;
                        err_q       <= misalign_s;
                        idx_q       <= req_idx_s;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (we_q || err_q) ? 32'h0000_0000 : arr_rdata_s;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0000_0000;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed load/store vectors against a transaction-level model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_be = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    dmem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory array plus response deadline in edge counts.
    bit [31:0] mdl_mem [DEPTH];
    bit        e_ready, e_valid, e_err, pend, p_err, mis;
    bit [31:0] e_rdata, p_data;
    int        edge_n, due;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend = 1'b0; e_ready = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_rdata = 32'h0; edge_n = 0;
        end else begin
            edge_n++;
            if (e_valid) begin
                if (rsp_ready) begin
                    e_valid = 1'b0; pend = 1'b0; e_ready = 1'b1;
                end
            end else if (pend) begin
                if (edge_n == due) begin
                    e_valid = 1'b1; e_rdata = p_data; e_err = p_err;
                end
            end else if (e_ready && req_valid) begin
`ifdef DMEM_ALIGN_CHK_EN
                mis = (req_addr[1:0] != 2'b00);
`else
                mis = 1'b0;
`endif
                pend = 1'b1; due = edge_n + LAT; e_ready = 1'b0; p_err = mis;
                if (req_we) begin
                    p_data = 32'h0;
                    if (!mis) begin
                        for (int i = 0; i < 4; i++)
                            if (req_be[i]) mdl_mem[req_addr[11:2]][8*i +: 8] = req_wdata[8*i +: 8];
                    end
                end else begin
                    p_data = mis ? 32'h0 : mdl_mem[req_addr[11:2]];
                end
            end else begin
                e_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            check("cyc_req_ready", 32'(req_ready), 32'(e_ready));
            check("cyc_rsp_valid", 32'(rsp_valid), 32'(e_valid));
            check("cyc_busy", 32'(busy), 32'(pend));
            if (e_valid) begin
                check("cyc_rsp_rdata", rsp_rdata, e_rdata);
                check("cyc_rsp_err", 32'(rsp_err), 32'(e_err));
            end
        end
    end

    // Drive a request at the current negedge and return at the negedge after it is accepted.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n >= 20), 32'd0);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA5A5_A5A5; req_be = 4'hF;
    endtask

    task automatic finish_req(input int hold, output logic [31:0] rd, output logic err);
        int lat;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LAT));
        rd = rsp_rdata; err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_rdata", rsp_rdata, rd);
            check("hold_err", 32'(rsp_err), 32'(err));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, output logic [31:0] rd, output logic err);
        start_req(we, addr, wdata, be);
        finish_req(hold, rd, err);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);

        // 1: full-word store then load
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        check("t1_store_rdata", rd, 32'h0);
        check("t1_store_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("t1_load", rd, 32'hDEAD_BEEF);

        // 2: partial and empty byte enables
        do_req(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rd, er);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("t2_lane0", rd, 32'hDEAD_BEAA);
        do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
        check("t2_be0_rsp", rd, 32'h0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("t2_be0_unchanged", rd, 32'hDEAD_BEAA);

        // 3: response back-pressure, then an immediately following request
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 3, rd, er);
        check("t3_held_load", rd, 32'hDEAD_BEAA);
        do_req(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, 0, rd, er);
        do_req(1'b0, 32'h14, 32'h0, 4'h0, 1, rd, er);
        check("t3_next_load", rd, 32'h0BAD_F00D);

        // 4: address wrap-around at DEPTH*4 bytes
        do_req(1'b1, 32'h0, 32'h0000_1111, 4'hF, 0, rd, er);
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er);
        check("t4_wrap", rd, 32'h0000_1111);

        // 5: reset during WAIT of a load, then of a store
        start_req(1'b0, 32'h10, 32'h0, 4'h0);
        rst = 1'b0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_ready", 32'(req_ready), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_ready_after_rel", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        start_req(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        check("t5_store_kept", rd, 32'h1234_5678);

        // 6: misaligned store
        do_req(1'b1, 32'h13, 32'h55AA_55AA, 4'hF, 0, rd, er);
        check("t6_rdata", rd, 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
        check("t6_err", 32'(er), 32'd1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("t6_word_unchanged", rd, 32'hDEAD_BEAA);
`else
        check("t6_err", 32'(er), 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        check("t6_word_written", rd, 32'h55AA_55AA);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t expected=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule
